pc_sequencer: RTL

- Parametrised successor to the simple PC register: owns the architectural fetch PC and sequences it.
- Sits between hazard/branch/trap control and the fetch stage.
- Adds a valid/ready handshake to fetch, prioritised trap and redirect, halt/resume, a boot state, and configurable reset and trap vectors.
- Sequential: 3-state FSM plus PC register; next-PC selection is combinational.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_next_sel.sv | 69 ++++++
 rtl/pc_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch PC sequencer.
// Latency: n/a (types, constants and a compile-time helper only).
// Backpressure: n/a.
//
// Contents:
//   pc_state_e         - sequencer FSM state; its encoding is visible on state_o
//   PC_*_DEF           - default reset/trap vectors and instruction size
//   instr_lsb()        - number of PC low bits that must be zero for an aligned PC
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR_DEF  = 32'h0000_0004;
    localparam int          PC_INSTR_BYTES_DEF  = 4;

    // INSTR_BYTES is a power of two >= 2, so the result is always >= 1.
    function automatic int instr_lsb(input int instr_bytes);
        return $clog2(instr_bytes);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap > redirect > sequential increment > hold.
// Latency: purely combinational, zero cycles.
// Backpressure: the increment is taken only in RUN with pc_ready set; otherwise the PC holds.
//
// Ports:
//   state, pc                    - current FSM state and registered PC
//   trap, redirect, redirect_pc  - control requests and the redirect target
//   pc_ready                     - fetch accepted the current PC
//   pc_next, pc_plus             - selected next PC and pc + INSTR_BYTES
//   misalign_hit                 - present only with PC_ALIGN_CHECK_EN
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned redirect diverts to the trap vector).
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = PC_TRAP_VECTOR_DEF,
    parameter int                    INSTR_BYTES = PC_INSTR_BYTES_DEF
) (
    input  pc_state_e             state,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  trap,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  pc_ready,
    output logic [DATA_WIDTH-1:0] pc_next,
    output logic [DATA_WIDTH-1:0] pc_plus
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                  misalign_hit
`endif
);

`ifdef PC_ALIGN_CHECK_EN
    localparam int LSB = instr_lsb(INSTR_BYTES);
    logic misaligned;
    assign misaligned = |redirect_pc[LSB-1:0];
`endif

    // Wraps modulo 2^DATA_WIDTH by construction of the sized add.
    assign pc_plus = pc + DATA_WIDTH'(INSTR_BYTES);

    always_comb begin
        pc_next = pc;
`ifdef PC_ALIGN_CHECK_EN
        misalign_hit = 1'b0;
`endif
        // BOOT ignores every control input; HALTED honours trap/redirect
        // but never advances, since nothing is being offered to fetch.
        if (state != BOOT) begin
            if (trap) begin
                pc_next = TRAP_VECTOR;
            end else if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
                if (misaligned) begin
                    pc_next      = TRAP_VECTOR;
                    misalign_hit = 1'b1;
                end else begin
                    pc_next = redirect_pc;
                end
`else
                pc_next = redirect_pc;
`endif
            end else if (state == RUN && pc_ready) begin
                pc_next = pc_plus;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the architectural fetch PC and offers it to fetch with a valid/ready handshake.
// Latency: PC and valid are registered; control inputs take effect on the next clock edge.
// Backpressure: while valid and not ready, the PC holds unless a trap or redirect flushes it.
//
// Ports:
//   clk, rst                          - clock; synchronous active-high reset
//   trap_i, redirect_i, redirect_pc_i - trap request, branch/jump redirect and its target
//   halt_i, resume_i                  - enter / leave HALTED
//   pc_ready_i                        - fetch accepts pc_o this cycle
//   pc_o, pc_valid_o, pc_plus_o       - registered PC, fetch request, pc_o + INSTR_BYTES
//   state_o                           - FSM state (BOOT=0, RUN=1, HALTED=2)
//   misalign_o                        - one-cycle pulse after a misaligned redirect
//                                       (present only with PC_ALIGN_CHECK_EN)
// Optional feature macro: PC_ALIGN_CHECK_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR_DEF,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = PC_TRAP_VECTOR_DEF,
    parameter int                    INSTR_BYTES  = PC_INSTR_BYTES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trap_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    input  logic                  halt_i,
    input  logic                  resume_i,
    input  logic                  pc_ready_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  pc_valid_o,
    output logic [DATA_WIDTH-1:0] pc_plus_o,
    output logic [1:0]            state_o
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                  misalign_o
`endif
);

    pc_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_next;

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_hit;
`endif

    pc_next_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .TRAP_VECTOR(TRAP_VECTOR),
        .INSTR_BYTES(INSTR_BYTES)
    ) u_next_sel (
        .state      (state_q),
        .pc         (pc_q),
        .trap       (trap_i),
        .redirect   (redirect_i),
        .redirect_pc(redirect_pc_i),
        .pc_ready   (pc_ready_i),
        .pc_next    (pc_next),
        .pc_plus    (pc_plus_o)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_hit(misalign_hit)
`endif
    );

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_next;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= misalign_hit;
        end
    end
`endif

    // Next-state logic. A halt in RUN still lets that cycle's PC update land;
    // in HALTED a trap restarts fetch at the trap vector, and resume beats halt.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_i) state_d = HALTED;
            HALTED:  if (trap_i || resume_i) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Outputs decode registered state only, so valid has no input-to-output path.
    always_comb begin
        pc_valid_o = (state_q == RUN);
        state_o    = state_q;
        pc_o       = pc_q;
    end

endmodule
